// File: rtl/simd_acc_pkg.sv
// -----------------------------------------------------------------------------
// simd_acc_pkg
// Shared types and helpers for the lane-partitioned SIMD accumulator.
//   lane_mode_e : how the datapath is split into lanes (1, 2 or 4 lanes)
//   state_e     : job-control states of the accumulator
//   decode_mode : maps the raw 2-bit mode field onto a lane mode
//   lane_count  : number of active lanes for a given lane mode
// -----------------------------------------------------------------------------
package simd_acc_pkg;

    typedef enum logic [1:0] {
        LANES_1 = 2'd0,
        LANES_2 = 2'd1,
        LANES_4 = 2'd2
    } lane_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The unused encoding 3 behaves like a single full-width lane.
    function automatic lane_mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return LANES_2;
            2'd2:    return LANES_4;
            default: return LANES_1;
        endcase
    endfunction

    function automatic int lane_count(input lane_mode_e mode);
        case (mode)
            LANES_2: return 2;
            LANES_4: return 4;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/simd_lane_adder.sv
// -----------------------------------------------------------------------------
// simd_lane_adder
// Combinational lane-partitioned two's-complement adder.
// The datapath is built from four DATA_W/4 slices; the lane mode decides which
// slice-to-slice carries are allowed, so wider lanes are formed by chaining
// slices and no carry ever crosses a lane boundary.
// Ports:
//   a, b : packed lane operands, lane 0 in the LSBs
//   mode : lane partitioning
//   sum  : packed lane results (saturated or wrapped depending on SAT_EN)
//   ovf  : per-lane signed overflow, bit i = lane i, unused lanes read 0
// -----------------------------------------------------------------------------
module simd_lane_adder
    import simd_acc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter bit SAT_EN = 1'b1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  lane_mode_e        mode,
    output logic [DATA_W-1:0] sum,
    output logic [3:0]        ovf
);

    localparam int SW = DATA_W / 4;

    logic [3:0]        carry_en;
    logic [DATA_W-1:0] raw_sum;
    logic [3:0]        slice_ovf;

    // Bit k enables the carry from slice k-1 into slice k. Slice 0 never
    // receives a carry; the 2-lane mode breaks the chain in the middle.
    always_comb begin
        carry_en = 4'b0000;
        case (mode)
            LANES_1: carry_en = 4'b1110;
            LANES_2: carry_en = 4'b1010;
            default: carry_en = 4'b0000;
        endcase
    end

    // Ripple through the four slices. slice_ovf is only meaningful for the
    // slice that holds the sign bit of a lane; the others are ignored later.
    always_comb begin : slice_add
        logic          carry;
        logic [SW:0]   wide;
        raw_sum   = '0;
        slice_ovf = '0;
        carry     = 1'b0;
        wide      = '0;
        for (int k = 0; k < 4; k++) begin
            wide = {1'b0, a[k*SW +: SW]} + {1'b0, b[k*SW +: SW]}
                 + {{SW{1'b0}}, carry & carry_en[k]};
            raw_sum[k*SW +: SW] = wide[SW-1:0];
            carry = wide[SW];
            slice_ovf[k] = (a[k*SW+SW-1] == b[k*SW+SW-1])
                        && (wide[SW-1] != a[k*SW+SW-1]);
        end
    end

    // Each slice looks up the top slice of its lane. When that lane overflows
    // and saturation is enabled, the whole lane is replaced by the clamp value
    // whose sign follows the operands: 0111..1 for positive, 1000..0 for
    // negative. The top slice carries the sign bit, lower slices are fill.
    always_comb begin : lane_select
        logic [1:0] top;
        logic       sign;
        sum  = raw_sum;
        top  = 2'd0;
        sign = 1'b0;
        for (int k = 0; k < 4; k++) begin
            case (mode)
                LANES_1: top = 2'd3;
                LANES_2: top = 2'(k) | 2'd1;
                default: top = 2'(k);
            endcase
            sign = a[top*SW + SW - 1];
            if (SAT_EN && slice_ovf[top]) begin
                if (2'(k) == top) begin
                    sum[k*SW +: SW] = {sign, {(SW-1){~sign}}};
                end else begin
                    sum[k*SW +: SW] = {SW{~sign}};
                end
            end
        end
    end

    // Report overflow per lane, using the sign slice of each lane.
    always_comb begin
        ovf = 4'b0000;
        case (mode)
            LANES_1: ovf[0] = slice_ovf[3];
            LANES_2: begin
                ovf[0] = slice_ovf[1];
                ovf[1] = slice_ovf[3];
            end
            default: ovf = slice_ovf;
        endcase
    end

endmodule

// File: rtl/simd_accumulator.sv
// -----------------------------------------------------------------------------
// simd_accumulator
// Multi-cycle lane-partitioned accumulator. A job is started in IDLE with a
// lane mode and an operand count; that many operands are then summed lane by
// lane over a valid/ready stream, and one packed result with sticky per-lane
// overflow flags is offered on the output handshake.
// Ports:
//   clk_i, rst_i          : clock (rising edge), async active-high reset
//   start_i, mode_i, len_i: job request, sampled only in IDLE
//   in_valid_i/in_ready_o : operand handshake, in_data_i holds packed lanes
//   out_valid_o/out_ready_i: result handshake
//   out_data_o, out_ovf_o : registered packed sum and sticky lane flags
//   busy_o                : a job is in progress (not IDLE)
// -----------------------------------------------------------------------------
module simd_accumulator
    import simd_acc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [3:0]        out_ovf_o,
    output logic              busy_o
);

    state_e            state_q;
    state_e            state_d;
    lane_mode_e        mode_q;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] acc_q;
    logic [3:0]        ovf_q;
    logic [DATA_W-1:0] lane_sum;
    logic [3:0]        lane_ovf;

    simd_lane_adder #(
        .DATA_W (DATA_W),
        .SAT_EN (SAT_EN)
    ) u_lane_adder (
        .a    (acc_q),
        .b    (in_data_i),
        .mode (mode_q),
        .sum  (lane_sum),
        .ovf  (lane_ovf)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The handshake flags depend on the state only, so the
    // streaming side never sees a combinational path through this block.
    // A zero-length job skips straight to DONE with the cleared accumulator.
    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (in_valid_i && (count_q == CNT_W'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                busy_o      = 1'b1;
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Job datapath: latch the job on start, then fold each accepted operand
    // into the accumulator and OR its lane overflows into the sticky flags.
    // Nothing changes in DONE, which keeps the offered result stable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q  <= LANES_1;
            count_q <= '0;
            acc_q   <= '0;
            ovf_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mode_q  <= decode_mode(mode_i);
                        count_q <= len_i;
                        acc_q   <= '0;
                        ovf_q   <= '0;
                    end
                end
                ACC: begin
                    if (in_valid_i) begin
                        acc_q   <= lane_sum;
                        ovf_q   <= ovf_q | lane_ovf;
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data_o = acc_q;
    assign out_ovf_o  = ovf_q;

endmodule
